// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// Holds the state encoding, default payload width and the legal oversampling ratios.
package uart_rx_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PRESCALE_W     = 6;

  localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
  localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
  localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Any ratio other than 16 or 32 falls back to 8.
  function automatic logic [PRESCALE_W-1:0] legal_prescale(input logic [PRESCALE_W-1:0] p);
    logic [PRESCALE_W-1:0] r;
    r = PRESCALE_8;
    if (p == PRESCALE_16 || p == PRESCALE_32) r = p;
    return r;
  endfunction

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and bit counter for one UART frame.
// Both counters clear whenever the receiver is not inside a frame.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BIT_CNT_W  = $clog2(DATA_WIDTH + 4)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [PRESCALE_W-1:0] edge_cnt_o,
  output logic [BIT_CNT_W-1:0]  bit_cnt_o,
  output logic                  bit_done_o
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

  assign bit_done_o = enable_i && (edge_cnt_q == prescale_i - PRESCALE_W'(1));

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (!enable_i) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (bit_done_o) begin
      edge_cnt_d = '0;
      bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
    end else begin
      edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt_o = edge_cnt_q;
  assign bit_cnt_o  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection, 3-sample majority voting, LSB-first
// deserialisation, parity handshake with an external checker and stop-bit check.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  parity_error,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  sampled_bit,
  output logic                  parity_check_en,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stop_err,
  output logic                  strt_glitch
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 4);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_WIDTH);

  rx_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [2:0]            samp_q, samp_d;
  logic                  sampled_bit_q, sampled_bit_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  pce_q, pce_d;
  logic                  dv_q, dv_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_err_q, stop_err_d;
  logic                  glitch_q, glitch_d;

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  bit_done;
  logic [PRESCALE_W-1:0] half, cnt_vote, cnt_shift;
  logic                  in_frame, in_window;

  assign in_frame  = (state_q != ST_IDLE);
  assign half      = {1'b0, prescale_q[PRESCALE_W-1:1]};
  assign cnt_vote  = half + PRESCALE_W'(1);
  assign cnt_shift = half + PRESCALE_W'(2);
  assign in_window = (edge_cnt == half - PRESCALE_W'(2)) || (edge_cnt == half - PRESCALE_W'(1)) ||
                     (edge_cnt == half);

  uart_rx_edge_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .enable_i   (in_frame),
    .prescale_i (prescale_q),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt),
    .bit_done_o (bit_done)
  );

  always_comb begin
    state_d       = state_q;
    prescale_d    = prescale_q;
    samp_d        = samp_q;
    sampled_bit_d = sampled_bit_q;
    p_data_d      = p_data_q;
    pce_d         = 1'b0;
    dv_d          = 1'b0;
    par_err_d     = 1'b0;
    stop_err_d    = 1'b0;
    glitch_d      = 1'b0;

    // Three captures around mid-bit, vote registered one edge after the last capture.
    if (in_frame && in_window) samp_d = {samp_q[1:0], rx_in};
    if (in_frame && edge_cnt == cnt_vote) sampled_bit_d = majority3(samp_q);

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_in) begin
          state_d    = ST_START;
          prescale_d = legal_prescale(prescale);
        end
      end
      ST_START: begin
        if (bit_done) begin
          if (sampled_bit_q) begin
            glitch_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (edge_cnt == cnt_shift) p_data_d = {sampled_bit_q, p_data_q[DATA_WIDTH-1:1]};
        if (bit_done && bit_cnt == LAST_DATA_BIT) state_d = par_en ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        // Registered so the enable is high while edge_cnt reads half+2.
        pce_d = (edge_cnt == cnt_vote);
        if (bit_done) begin
          if (parity_error) begin
            par_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          dv_d       = sampled_bit_q;
          stop_err_d = !sampled_bit_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      prescale_q    <= PRESCALE_8;
      samp_q        <= '1;
      sampled_bit_q <= 1'b1;
      p_data_q      <= '0;
      pce_q         <= 1'b0;
      dv_q          <= 1'b0;
      par_err_q     <= 1'b0;
      stop_err_q    <= 1'b0;
      glitch_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      prescale_q    <= prescale_d;
      samp_q        <= samp_d;
      sampled_bit_q <= sampled_bit_d;
      p_data_q      <= p_data_d;
      pce_q         <= pce_d;
      dv_q          <= dv_d;
      par_err_q     <= par_err_d;
      stop_err_q    <= stop_err_d;
      glitch_q      <= glitch_d;
    end
  end

  assign p_data          = p_data_q;
  assign sampled_bit     = sampled_bit_q;
  assign parity_check_en = pce_q;
  assign data_valid      = dv_q;
  assign par_err         = par_err_q;
  assign stop_err        = stop_err_q;
  assign strt_glitch     = glitch_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: serial line waveforms are built per segment and a
// frame-level model predicts every output pulse, its cycle and the payload.
module tb_uart_rx_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_in = 1'b1;
  logic [5:0]    prescale = 6'd8;
  logic          par_en = 1'b0;
  logic          parity_error = 1'b0;
  logic [DW-1:0] p_data;
  logic          sampled_bit, parity_check_en, data_valid, par_err, stop_err, strt_glitch;

  uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_in           (rx_in),
    .prescale        (prescale),
    .par_en          (par_en),
    .parity_error    (parity_error),
    .p_data          (p_data),
    .sampled_bit     (sampled_bit),
    .parity_check_en (parity_check_en),
    .data_valid      (data_valid),
    .par_err         (par_err),
    .stop_err        (stop_err),
    .strt_glitch     (strt_glitch)
  );

  always #5 clk = ~clk;

  // Event kinds
  localparam int K_DV = 0, K_PERR = 1, K_SERR = 2, K_GLITCH = 3, K_PCE = 4;

  typedef struct {
    int t;
    int kind;
    int data;
  } ev_t;

  bit   line[$];
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  int   det_q[$];
  int   n_total = 0;
  int   n_bad = 0;
  int   multi_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_total++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  function automatic bit ln(input int i);
    return (i >= 0 && i < line.size()) ? line[i] : 1'b1;
  endfunction

  function automatic bit maj_at(input int i);
    int s;
    s = int'(ln(i)) + int'(ln(i + 1)) + int'(ln(i + 2));
    return s >= 2;
  endfunction

  function automatic int eff_p(input int p);
    return (p == 16 || p == 32) ? p : 8;
  endfunction

  task automatic add_bits(input bit v, input int n);
    for (int i = 0; i < n; i++) line.push_back(v);
  endtask

  task automatic add_frame(input int p, input int data, input bit pe, input bit par_flip, input bit stop_v);
    add_bits(1'b0, p);
    for (int b = 0; b < DW; b++) add_bits(data[b], p);
    if (pe) add_bits((^data[DW-1:0]) ^ par_flip, p);
    add_bits(stop_v, p);
  endtask

  task automatic push_exp(input int t, input int kind, input int data);
    ev_t e;
    e.t = t; e.kind = kind; e.data = data;
    exp_q.push_back(e);
  endtask

  // Frame-level reference: bit b of a frame detected at D is the majority of
  // line[D+b*P+P/2-1 .. D+b*P+P/2+1]; each verdict lands at the end of its bit.
  task automatic build_model(input int p, input bit pe);
    int t, d, data, nb;
    bit pb;
    exp_q.delete();
    det_q.delete();
    t = 0;
    while (t < line.size()) begin
      if (ln(t) == 1'b0) begin
        d = t;
        det_q.push_back(d);
        if (maj_at(d + p/2 - 1)) begin
          push_exp(d + p, K_GLITCH, 0);
          t = d + p + 1;
        end else begin
          data = 0;
          for (int b = 0; b < DW; b++) data |= int'(maj_at(d + (b + 1)*p + p/2 - 1)) << b;
          nb = DW + 1;
          if (pe) begin
            pb = maj_at(d + (DW + 1)*p + p/2 - 1);
            push_exp(d + (DW + 1)*p + p/2 + 2, K_PCE, data);
            nb = DW + 2;
          end
          if (pe && ((^data[DW-1:0]) ^ pb)) begin
            push_exp(d + (DW + 2)*p, K_PERR, data);
            t = d + (DW + 2)*p + 1;
          end else begin
            push_exp(d + (nb + 1)*p, maj_at(d + nb*p + p/2 - 1) ? K_DV : K_SERR, data);
            t = d + (nb + 1)*p + 1;
          end
        end
      end else begin
        t++;
      end
    end
  endtask

  task automatic check_reset(input string name);
    check({name, ".p_data"}, p_data, 0);
    check({name, ".sampled_bit"}, sampled_bit, 1);
    check({name, ".pce"}, parity_check_en, 0);
    check({name, ".data_valid"}, data_valid, 0);
    check({name, ".par_err"}, par_err, 0);
    check({name, ".stop_err"}, stop_err, 0);
    check({name, ".strt_glitch"}, strt_glitch, 0);
  endtask

  task automatic observe(input int t);
    int n;
    ev_t e;
    n = 0;
    e.t = t;
    if (data_valid)      begin e.kind = K_DV;     e.data = int'(p_data); obs_q.push_back(e); n++; end
    if (par_err)         begin e.kind = K_PERR;   e.data = int'(p_data); obs_q.push_back(e); n++; end
    if (stop_err)        begin e.kind = K_SERR;   e.data = int'(p_data); obs_q.push_back(e); n++; end
    if (strt_glitch)     begin e.kind = K_GLITCH; e.data = 0;            obs_q.push_back(e); n++; end
    if (n > 1) multi_cnt++;
    if (parity_check_en) begin
      e.kind = K_PCE; e.data = int'(p_data); obs_q.push_back(e);
      // Downstream even-parity checker, result held until the next request.
      parity_error = (^p_data) ^ sampled_bit;
    end
  endtask

  function automatic logic [5:0] junk_prescale();
    logic [5:0] v;
    case ($urandom_range(0, 5))
      0: v = 6'd8;
      1: v = 6'd16;
      2: v = 6'd32;
      3: v = 6'd0;
      4: v = 6'd5;
      default: v = 6'd63;
    endcase
    return v;
  endfunction

  // Streams the serial-line queue after a reset; prescale is correct only on detection edges.
  task automatic run_seg(input string name, input int p_drive, input bit pe, input int abort_k);
    int di, lim, n;
    ev_t ef[$];
    build_model(eff_p(p_drive), pe);
    obs_q.delete();
    multi_cnt = 0;
    di = 0;
    @(negedge clk);
    rst = 1'b0; rx_in = 1'b1; par_en = pe; parity_error = 1'b0;
    @(negedge clk);
    for (int k = 0; k <= line.size() + 1; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (k - 1 == abort_k) begin
          check_reset({name, ".abort"});
          break;
        end
        observe(k - 1);
      end
      rx_in = ln(k);
      if (di < det_q.size() && det_q[di] == k) begin
        prescale = 6'(p_drive);
        di++;
      end else begin
        prescale = junk_prescale();
      end
      rst = (k == abort_k) ? 1'b0 : 1'b1;
    end
    lim = (abort_k >= 0) ? abort_k : 32'h7fffffff;
    foreach (exp_q[i]) if (exp_q[i].t < lim) ef.push_back(exp_q[i]);
    check({name, ".n_events"}, obs_q.size(), ef.size());
    n = (obs_q.size() < ef.size()) ? obs_q.size() : ef.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.ev%0d.kind", name, i), obs_q[i].kind, ef[i].kind);
      check($sformatf("%s.ev%0d.t", name, i), obs_q[i].t, ef[i].t);
      check($sformatf("%s.ev%0d.data", name, i), obs_q[i].data, ef[i].data);
    end
    check({name, ".onehot"}, multi_cnt, 0);
  endtask

  // nth observed event of a kind, timed relative to the det_idx-th frame start.
  task automatic check_rel(input string tag, input int kind, input int nth, input int det_idx,
                           input int rel, input int data_exp);
    int seen, got_t, got_d;
    seen = 0; got_t = -1; got_d = -1;
    foreach (obs_q[i]) begin
      if (obs_q[i].kind == kind) begin
        if (seen == nth && det_idx < det_q.size()) begin
          got_t = obs_q[i].t - det_q[det_idx];
          got_d = obs_q[i].data;
        end
        seen++;
      end
    end
    check({tag, ".rel_t"}, got_t, rel);
    if (data_exp >= 0) check({tag, ".data"}, got_d, data_exp);
  endtask

  initial begin
    int p, p_drive, r, gap, data;
    bit pe, prev_gap0, pflip, stop_v;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("init");

    // Even parity, good frame
    line.delete(); add_bits(1, 3); add_frame(8, 'hA5, 1, 0, 1); add_bits(1, 20);
    run_seg("a5_par_ok", 8, 1, -1);
    check_rel("a5_par_ok.dv", K_DV, 0, 0, 88, 'hA5);

    // Two-cycle low pulse
    line.delete(); add_bits(1, 3); add_bits(0, 2); add_bits(1, 20);
    run_seg("glitch", 8, 0, -1);
    check_rel("glitch.sg", K_GLITCH, 0, 0, 8, -1);

    // Wrong parity bit
    line.delete(); add_bits(1, 3); add_frame(8, 'hA5, 1, 1, 1); add_bits(1, 20);
    run_seg("a5_par_bad", 8, 1, -1);
    check_rel("a5_par_bad.pce", K_PCE, 0, 0, 9*8 + 6, 'hA5);
    check_rel("a5_par_bad.perr", K_PERR, 0, 0, 80, 'hA5);

    // Stop bit low
    line.delete(); add_bits(1, 4); add_frame(16, 'h3C, 0, 0, 0); add_bits(1, 40);
    run_seg("stop_bad", 16, 0, -1);
    check_rel("stop_bad.serr", K_SERR, 0, 0, 160, 'h3C);

    // Back-to-back frames, second start bit directly after the first stop bit
    line.delete(); add_bits(1, 4); add_frame(32, 'h00, 0, 0, 1); add_frame(32, 'hFF, 0, 0, 1);
    add_bits(1, 70);
    run_seg("b2b", 32, 0, -1);
    check_rel("b2b.dv0", K_DV, 0, 0, 320, 'h00);
    check_rel("b2b.dv1", K_DV, 1, 1, 320, 'hFF);

    // Reset during data bit 4, then a clean frame
    line.delete(); add_bits(1, 3); add_frame(16, 'h0F, 0, 0, 1); add_bits(1, 40);
    run_seg("abort", 16, 0, 3 + 5*16 + 8 + 4);
    line.delete(); add_bits(1, 2); add_frame(16, 'h5A, 0, 0, 1); add_bits(1, 40);
    run_seg("after_abort", 16, 0, -1);
    check_rel("after_abort.dv", K_DV, 0, 0, 160, 'h5A);

    // Illegal ratio falls back to 8
    line.delete(); add_bits(1, 3); add_frame(8, 'h96, 0, 0, 1); add_bits(1, 20);
    run_seg("p_illegal", 12, 0, -1);
    check_rel("p_illegal.dv", K_DV, 0, 0, 80, 'h96);

    for (int s = 0; s < 6; s++) begin
      case ($urandom_range(0, 3))
        0: p_drive = 8;
        1: p_drive = 16;
        2: p_drive = 32;
        default: p_drive = 20;
      endcase
      p = eff_p(p_drive);
      pe = 1'($urandom_range(0, 1));
      prev_gap0 = 1'b0;
      line.delete(); add_bits(1, 3);
      for (int f = 0; f < 4; f++) begin
        r = $urandom_range(0, 9);
        if (r == 0) begin
          add_bits(0, $urandom_range(1, p/2 - 2));
          add_bits(1, p + 2);
          prev_gap0 = 1'b0;
        end else begin
          data = $urandom_range(0, 255);
          pflip = pe && (r == 1);
          stop_v = pflip || (r != 2);
          add_frame(p, data, pe, pflip, stop_v);
          gap = prev_gap0 ? $urandom_range(1, 4) : $urandom_range(0, 4);
          prev_gap0 = (gap == 0);
          add_bits(1, gap);
        end
      end
      add_bits(1, 2*p + 4);
      run_seg($sformatf("rnd%0d", s), p_drive, pe, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning frame payload bits.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port rx_in  input  1  serial line, already synchronous to clk, idle high.
REQ-005 SHALL have port prescale  input  6  oversampling ratio P; legal values 8, 16, 32.
REQ-006 SHALL have port par_en  input  1  frame carries parity bit when high.
REQ-007 SHALL have port parity_error  input  1  registered result from downstream parity checker.
REQ-008 SHALL have port p_data  output  DATA_WIDTH  deserialized payload, LSB received first.
REQ-009 SHALL have port sampled_bit  output  1  majority-voted current bit value.
REQ-010 SHALL have port parity_check_en  output  1  one-cycle enable to parity checker.
REQ-011 SHALL have port data_valid  output  1  one-cycle pulse, p_data holds a good frame.
REQ-012 SHALL have port par_err  output  1  one-cycle pulse, parity failure.
REQ-013 SHALL have port stop_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-014 SHALL have port strt_glitch  output  1  one-cycle pulse, false start rejected.

Function
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL, in IDLE, latch prescale (illegal value treated as 8) and move to START with edge_cnt=0 on the edge where rx_in=0; that edge is frame cycle 0.
REQ-017 SHALL count edge_cnt 0..P-1 per bit, wrap to 0 and increment bit_cnt on edge_cnt=P-1; prescale changes mid-frame SHALL be ignored.
REQ-018 SHALL capture rx_in at edge_cnt = P/2-2, P/2-1, P/2 and register the majority into sampled_bit at edge_cnt=P/2+1 (visible from P/2+2 until next update).
REQ-019 SHALL, in START at edge_cnt=P-1: sampled_bit=1 -> pulse strt_glitch, go IDLE; else go DATA.
REQ-020 SHALL, in DATA, shift sampled_bit into p_data MSB with right shift at edge_cnt=P/2+2, giving LSB-first order; after DATA_WIDTH bits go PARITY if par_en else STOP.
REQ-021 SHALL, in PARITY, drive parity_check_en high for exactly the cycle edge_cnt=P/2+2; p_data SHALL not change outside DATA.
REQ-022 SHALL, in PARITY at edge_cnt=P-1, read parity_error: 1 -> pulse par_err, go IDLE, no data_valid; 0 -> go STOP.
REQ-023 SHALL, in STOP at edge_cnt=P-1: sampled_bit=0 -> pulse stop_err; else pulse data_valid; then go IDLE.
REQ-024 SHALL place data_valid one cycle after edge N*P, N=DATA_WIDTH+2(+1 if par_en); p_data SHALL hold until the next DATA shift.
REQ-025 SHALL accept a new start bit on the first IDLE cycle after STOP (back-to-back frames, no idle bit beyond stop).
REQ-026 SHALL never assert more than one of data_valid, par_err, stop_err, strt_glitch in a cycle.

Reset
REQ-027 SHALL, on rst=0 at a clock edge, force IDLE, edge_cnt=0, bit_cnt=0, p_data=0, sampled_bit=1, all pulse outputs and parity_check_en=0.
REQ-028 SHALL abort any frame in progress on reset with no output pulse; first frame after release starts cleanly.

Structure
REQ-029 SHALL take state encoding, DATA_WIDTH default and legal prescale constants from shared package uart_rx_pkg.
REQ-030 SHALL place edge_cnt/bit_cnt logic in sub-module uart_rx_edge_bit_counter (enable, P in; edge_cnt, bit_cnt, bit_done out).

Verification
REQ-031 SHALL verify P=8, par_en=1, even parity, 0xA5, parity bit 0, stop 1 -> data_valid one cycle after edge 88, p_data=0xA5.
REQ-032 SHALL verify P=8, rx_in low for 2 cycles only -> strt_glitch after edge 8, IDLE, no data_valid.
REQ-033 SHALL verify P=8, 0xA5 with parity bit 1 -> parity_check_en pulse at bit 9 edge_cnt=6, par_err pulse, no data_valid.
REQ-034 SHALL verify P=16, par_en=0, 0x3C with stop bit 0 -> stop_err after edge 160, no data_valid.
REQ-035 SHALL verify P=32, par_en=0, back-to-back 0x00 then 0xFF -> two data_valid pulses 320 cycles apart, p_data 0x00 then 0xFF.
REQ-036 SHALL verify rst=0 during DATA bit 4 -> all outputs reset values next cycle; following 0x5A frame received correctly.
